ks_adder_pipe: RTL and testbench

KS_ADDER_PIPE -- requirements
Module: ks_adder_pipe

---
 rtl/ks_adder_pipe_pkg.sv | 13 +
 rtl/ks_adder_pipe_if.sv | 28 ++
 rtl/ks_prefix_cell.sv | 12 +
 rtl/ks_adder_pipe.sv | 97 +++++++++
 tb/tb_ks_adder_pipe.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ks_adder_pipe_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
package ks_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ks_adder_pipe_if.sv
// Operand/result handshake bundle for ks_adder_pipe.
interface ks_adder_pipe_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone prefix operator: combines a higher (g,p) group with a lower one.
module ks_prefix_cell
  import ks_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t o
);

  assign o = '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: one prefix level per stage, global
// stall from the output register, valid chain kept beside the data path.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LEVELS = ks_levels(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  ks_adder_pipe_if.slave bus
);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0 ||
      LEVELS != ks_levels(WIDTH)) begin : g_param_check
    $error("ks_adder_pipe: WIDTH must be a power of two in 4..64, LEVELS derived");
  end

  logic                 stall;
  logic [LEVELS:0]      vld;
  logic [WIDTH-1:0]     b_eff;
  gp_t  [WIDTH:0]       gp_in;
  gp_t  [WIDTH:0]       gp_q [LEVELS+1];
  gp_t  [WIDTH:0]       gp_d [1:LEVELS];
  logic [WIDTH-1:0]     p_q  [LEVELS+1];
  logic [WIDTH-1:0]     carry;
  logic                 cout_d;
  logic                 ovf_d;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // Element 0 carries the effective carry-in as a pure generate; bit i sits at i+1.
  always_comb begin
    b_eff    = bus.in_sub ? ~bus.in_b : bus.in_b;
    gp_in    = '0;
    gp_in[0] = '{g: bus.in_sub | bus.in_cin, p: 1'b0};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      gp_in[i+1] = '{g: bus.in_a[i] & b_eff[i], p: bus.in_a[i] ^ b_eff[i]};
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int SPAN = 1 << (k - 1);
    for (genvar j = 0; j <= WIDTH; j++) begin : g_bit
      if (j >= SPAN) begin : g_cell
        ks_prefix_cell u_cell (
          .hi (gp_q[k-1][j]),
          .lo (gp_q[k-1][j-SPAN]),
          .o  (gp_d[k][j])
        );
      end else begin : g_pass
        assign gp_d[k][j] = gp_q[k-1][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      gp_q[0] <= gp_in;
      p_q[0]  <= bus.in_a ^ b_eff;
      for (int unsigned k = 1; k <= LEVELS; k++) begin
        gp_q[k] <= gp_d[k];
        p_q[k]  <= p_q[k-1];
      end
    end
  end

  // Group at the top element spans bits 0..WIDTH-1 only; merge element 0 for cout.
  always_comb begin
    carry = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry[i] = gp_q[LEVELS][i].g;
    end
    cout_d = gp_q[LEVELS][WIDTH].g | (gp_q[LEVELS][WIDTH].p & gp_q[LEVELS][0].g);
    ovf_d  = carry[WIDTH-1] ^ cout_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_cout  <= 1'b0;
      bus.out_ovf   <= 1'b0;
    end else if (!stall) begin
      vld           <= {vld[LEVELS-1:0], bus.in_valid};
      bus.out_valid <= vld[LEVELS];
      if (vld[LEVELS]) begin
        bus.out_sum  <= p_q[LEVELS] ^ carry;
        bus.out_cout <= cout_d;
        bus.out_ovf  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe at WIDTH=16 and WIDTH=4 against an arithmetic reference.
module tb_ks_adder_pipe;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ks_adder_pipe_if #(.WIDTH(16)) bus16 ();
  ks_adder_pipe_if #(.WIDTH(4))  bus4 ();

  ks_adder_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  ks_adder_pipe #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  int checks   = 0;
  int failures = 0;
  int outs16   = 0;
  int outs4    = 0;
  res_t q16[$];
  res_t q4[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input int unsigned w, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin, input logic sub);
    res_t   r;
    longint m, sa, sb, s, u;
    m  = longint'(1) << w;
    sa = (longint'(a) >= m / 2) ? longint'(a) - m : longint'(a);
    sb = (longint'(b) >= m / 2) ? longint'(b) - m : longint'(b);
    if (sub) begin
      u      = longint'(a) - longint'(b);
      s      = sa - sb;
      r.cout = (a >= b);
    end else begin
      u      = longint'(a) + longint'(b) + longint'(cin);
      s      = sa + sb + longint'(cin);
      r.cout = (u >= m);
    end
    if (u < 0) u = u + m;
    r.sum = 16'(u % m);
    r.ovf = (s >= m / 2) || (s < -(m / 2));
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
    end else begin
      if (bus16.out_valid) begin
        check("outq16", 64'(q16.size() > 0), 64'(1));
        if (q16.size() > 0) begin
          check("sum16",  64'(bus16.out_sum),  64'(q16[0].sum));
          check("cout16", 64'(bus16.out_cout), 64'(q16[0].cout));
          check("ovf16",  64'(bus16.out_ovf),  64'(q16[0].ovf));
          if (bus16.out_ready) begin
            void'(q16.pop_front());
            outs16++;
          end
        end
      end
      if (bus16.in_valid && bus16.in_ready)
        q16.push_back(model(16, bus16.in_a, bus16.in_b, bus16.in_cin, bus16.in_sub));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
    end else begin
      if (bus4.out_valid) begin
        check("outq4", 64'(q4.size() > 0), 64'(1));
        if (q4.size() > 0) begin
          check("sum4",  64'(bus4.out_sum),  64'(q4[0].sum));
          check("cout4", 64'(bus4.out_cout), 64'(q4[0].cout));
          check("ovf4",  64'(bus4.out_ovf),  64'(q4[0].ovf));
          if (bus4.out_ready) begin
            void'(q4.pop_front());
            outs4++;
          end
        end
      end
      if (bus4.in_valid && bus4.in_ready)
        q4.push_back(model(4, 16'(bus4.in_a), 16'(bus4.in_b), bus4.in_cin, bus4.in_sub));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] es,
                          input logic ec, input logic eo);
    int lat;
    bus16.in_a     = a;
    bus16.in_b     = b;
    bus16.in_cin   = cin;
    bus16.in_sub   = sub;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"},  64'(lat), 64'(6));
    check({tag, "_sum"},  64'(bus16.out_sum),  64'(es));
    check({tag, "_cout"}, 64'(bus16.out_cout), 64'(ec));
    check({tag, "_ovf"},  64'(bus16.out_ovf),  64'(eo));
    idle(3);
  endtask

  initial begin
    int   i, n, base, seen;
    logic rdy;
    logic [9:0] v;

    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0;
    bus16.in_cin = 1'b0;   bus16.in_sub = 1'b0; bus16.out_ready = 1'b1;
    bus4.in_valid = 1'b0;  bus4.in_a = '0;  bus4.in_b = '0;
    bus4.in_cin = 1'b0;    bus4.in_sub = 1'b0;  bus4.out_ready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus16.out_valid), 64'(0));
    check("rst_sum",   64'(bus16.out_sum),   64'(0));
    check("rst_cout",  64'(bus16.out_cout),  64'(0));
    check("rst_ovf",   64'(bus16.out_ovf),   64'(0));
    check("rst_ready", 64'(bus16.in_ready),  64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_ready", 64'(bus16.in_ready), 64'(1));
    idle(2);

    directed("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("subov", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("cinov", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Eight back-to-back ops with a six-cycle output stall.
    i = 0;
    base = outs16;
    for (int c = 0; c < 40; c++) begin
      bus16.out_ready = !(c >= 7 && c <= 12);
      if (i < 8) begin
        bus16.in_valid = 1'b1;
        bus16.in_a = 16'(i);
        bus16.in_b = 16'(i * 256);
        bus16.in_cin = 1'b0;
        bus16.in_sub = 1'b0;
      end else begin
        bus16.in_valid = 1'b0;
      end
      @(negedge clk);
      rdy = bus16.in_ready;
      if (c < 20) check("rdy_stall", 64'(rdy), 64'(!(c >= 7 && c <= 12)));
      @(posedge clk);
      #1;
      if (bus16.in_valid && rdy) i++;
    end
    check("stall_acc", 64'(i), 64'(8));
    check("stall_cnt", 64'(outs16 - base), 64'(8));
    check("stall_q",   64'(q16.size()), 64'(0));

    // Reset in cycle 3 after three accepts.
    base = outs16;
    for (int c = 0; c < 3; c++) begin
      bus16.in_valid = 1'b1;
      bus16.in_a = 16'($urandom);
      bus16.in_b = 16'($urandom);
      bus16.in_cin = 1'($urandom);
      bus16.in_sub = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus16.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst3_valid", 64'(bus16.out_valid), 64'(0));
    check("rst3_ready", 64'(bus16.in_ready),  64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus16.out_valid) seen++;
    end
    check("rst3_quiet", 64'(seen), 64'(0));
    check("rst3_cnt",   64'(outs16 - base), 64'(0));

    // Asynchronous reset while a result is held at the output.
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
    bus16.in_a = 16'hFFFF; bus16.in_b = 16'hFFFF;
    bus16.in_cin = 1'b0;   bus16.in_sub = 1'b0;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    n = 0;
    while (!bus16.out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("held_valid", 64'(bus16.out_valid), 64'(1));
    check("held_sum",   64'(bus16.out_sum),   64'(16'hFFFE));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus16.out_valid), 64'(0));
    check("arst_sum",   64'(bus16.out_sum),   64'(0));
    check("arst_cout",  64'(bus16.out_cout),  64'(0));
    check("arst_ready", 64'(bus16.in_ready),  64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus16.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus16.out_valid) seen++;
    end
    check("arst_quiet", 64'(seen), 64'(0));
    @(posedge clk);
    #1;

    // Random 16-bit traffic with bubbles and backpressure.
    base = outs16;
    n = 0;
    for (int c = 0; c < 3000 && n < 300; c++) begin
      bus16.out_ready = ($urandom_range(0, 9) < 7);
      bus16.in_valid  = ($urandom_range(0, 3) != 0);
      bus16.in_a   = 16'($urandom);
      bus16.in_b   = 16'($urandom);
      bus16.in_cin = 1'($urandom);
      bus16.in_sub = 1'($urandom);
      @(negedge clk);
      rdy = bus16.in_ready;
      @(posedge clk);
      #1;
      if (bus16.in_valid && rdy) n++;
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    idle(12);
    check("rand16_acc", 64'(n), 64'(300));
    check("rand16_cnt", 64'(outs16 - base), 64'(300));
    check("rand16_q",   64'(q16.size()), 64'(0));

    // WIDTH=4 exhaustive sweep with random backpressure.
    n = 0;
    for (int c = 0; c < 20000 && n < 1024; c++) begin
      v = 10'(n);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      bus4.in_valid  = ($urandom_range(0, 7) != 0);
      bus4.in_a   = v[9:6];
      bus4.in_b   = v[5:2];
      bus4.in_cin = v[1];
      bus4.in_sub = v[0];
      @(negedge clk);
      rdy = bus4.in_ready;
      @(posedge clk);
      #1;
      if (bus4.in_valid && rdy) n++;
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    idle(12);
    check("ex4_acc", 64'(n), 64'(1024));
    check("ex4_cnt", 64'(outs4), 64'(1024));
    check("ex4_q",   64'(q4.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog timeout at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
